// File: rtl/frame_scanout.sv
// Video timing generator and framebuffer scan-out with optional double buffering.
// Define FRAME_SCANOUT_DOUBLE_BUF_EN to enable the front/back buffer swap logic.
module frame_scanout #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 476,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  output logic [20:0] fb_addr_out,
  output logic        fb_rd_en_out,
  input  logic [23:0] fb_data_in,
  input  logic        swap_req_in,
  output logic        swap_ack_out,
  output logic        back_buf_out,
  output logic [23:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic        frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [20:0] FRAME_WORDS = 21'(H_ACTIVE * V_ACTIVE);
  localparam logic [20:0] LINE_WORDS  = 21'(H_ACTIVE);

  // ---------------------------------------------------------------------------
  // Raster counters; line_base tracks vcount*H_ACTIVE without a multiplier.
  // ---------------------------------------------------------------------------
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [20:0]   line_base;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_end;
  logic          at_origin;

  assign h_wrap    = (hcount == H_LAST);
  assign v_wrap    = (vcount == V_LAST);
  assign frame_end = h_wrap && v_wrap;
  assign at_origin = (hcount == '0) && (vcount == '0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount    <= '0;
      vcount    <= '0;
      line_base <= '0;
    end else if (h_wrap) begin
      hcount <= '0;
      if (v_wrap) begin
        vcount    <= '0;
        line_base <= '0;
      end else begin
        vcount    <= vcount + 1'b1;
        line_base <= line_base + LINE_WORDS;
      end
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer selection and swap handshake
  // ---------------------------------------------------------------------------
  logic front_buf;

`ifdef FRAME_SCANOUT_DOUBLE_BUF_EN
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t swap_state;
  swap_state_t swap_state_nxt;
  logic        front_buf_nxt;
  logic        swap_ack_nxt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      swap_state   <= IDLE;
      front_buf    <= 1'b0;
      swap_ack_out <= 1'b0;
    end else begin
      swap_state   <= swap_state_nxt;
      front_buf    <= front_buf_nxt;
      swap_ack_out <= swap_ack_nxt;
    end
  end

  // A request on the boundary cycle itself still swaps at that boundary.
  always_comb begin
    swap_state_nxt = swap_state;
    front_buf_nxt  = front_buf;
    swap_ack_nxt   = 1'b0;
    if (frame_end) begin
      if ((swap_state == PENDING) || swap_req_in) begin
        front_buf_nxt = ~front_buf;
        swap_ack_nxt  = 1'b1;
      end
      swap_state_nxt = IDLE;
    end else if (swap_req_in) begin
      swap_state_nxt = PENDING;
    end
  end

  assign back_buf_out = ~front_buf;
`else
  logic unused_swap_req;

  assign unused_swap_req = swap_req_in;
  assign front_buf       = 1'b0;
  assign swap_ack_out    = 1'b0;
  assign back_buf_out    = 1'b0;
`endif

  // The frame's buffer index is latched at (0,0); the origin pixel itself
  // reads front_buf directly since the latch lands one cycle later.
  logic        frame_buf;
  logic        addr_buf;
  logic [20:0] pix_addr;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_buf <= 1'b0;
    end else if (at_origin) begin
      frame_buf <= front_buf;
    end
  end

  assign addr_buf = at_origin ? front_buf : frame_buf;
  assign pix_addr = (addr_buf ? FRAME_WORDS : 21'd0) + line_base + 21'(hcount);

  // ---------------------------------------------------------------------------
  // Timing decode, read request and 2-stage alignment pipeline
  // ---------------------------------------------------------------------------
  logic active;
  logic hs_now;
  logic vs_now;

  assign active = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_now = (hcount >= HS_BEG) && (hcount < HS_END);
  assign vs_now = (vcount >= VS_BEG) && (vcount < VS_END);

  // Tap vectors are packed {frame_start, vsync, hsync, de}.
  logic [3:0] tap_p0;
  logic [3:0] tap_d1;
  logic [3:0] tap_d2;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fb_addr_out  <= '0;
      fb_rd_en_out <= 1'b0;
      tap_p0       <= '0;
      tap_d1       <= '0;
      tap_d2       <= '0;
    end else begin
      fb_rd_en_out <= active;
      if (active) begin
        fb_addr_out <= pix_addr;
      end
      tap_p0 <= {at_origin, vs_now, hs_now, active};
      tap_d1 <= tap_p0;
      tap_d2 <= tap_d1;
    end
  end

  assign de_out          = tap_d2[0];
  assign hsync_out       = tap_d2[1];
  assign vsync_out       = tap_d2[2];
  assign frame_start_out = tap_d2[3];
  assign rgb_out         = de_out ? fb_data_in : 24'h0;

endmodule
